as_hazard_ctrl: RTL and testbench
=================================

AS_HAZARD_CTRL -- requirements
Module: as_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-index width.
REQ-002 SHALL have parameter CNT_W, default 32, performance-counter width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 15, max dmem wait cycles before error.
REQ-004 SHALL have ports, in this order:
- clk_i  in  1  core clock.
- rst_i  in  1  reset, asynchronous, active-high.
- id_rs1_i, id_rs2_i  in  REG_ADDR_W  decode-stage sources.
- id_ex_rs1_i, id_ex_rs2_i, id_ex_rd_i  in  REG_ADDR_W  execute-stage regs.
- id_ex_memrd_i  in  1  load in execute.
- ex_mem_rd_i  in  REG_ADDR_W; ex_mem_reg_wr_i, ex_mem_memrd_i, ex_mem_memwr_i  in  1  mem-stage controls.
- mem_wb_rd_i  in  REG_ADDR_W; mem_wb_reg_wr_i  in  1  writeback controls.
- branch_taken_i  in  1  branch/jump resolved taken in execute.
- dmem_ack_i  in  1  data memory access complete.
- forward_a_o, forward_b_o  out  2  ALU operand mux selects.
- stall_if_o, stall_id_o  out  1  hold PC and IF/ID register.
- flush_id_o, flush_ex_o  out  1  bubble into IF/ID and ID/EX.
- freeze_o  out  1  hold all pipeline registers.
- state_o  out  2  FSM state.
- mem_err_o  out  1  sticky dmem timeout.
- stall_cnt_o, flush_cnt_o  out  CNT_W  performance counters.

Function
REQ-005 forward_a_o SHALL be 2 when ex_mem_reg_wr_i=1, ex_mem_rd_i!=0 and ex_mem_rd_i==id_ex_rs1_i; else 1 when mem_wb_reg_wr_i=1, mem_wb_rd_i!=0 and mem_wb_rd_i==id_ex_rs1_i; else 0; combinational, zero latency.
REQ-006 forward_b_o SHALL follow REQ-005 using id_ex_rs2_i.
REQ-007 FSM states SHALL be RUN=0, LDSTALL=1, MEMWAIT=2, FLUSH=3, output on state_o.
REQ-008 MEMWAIT entry SHALL occur from any state when (ex_mem_memrd_i|ex_mem_memwr_i)=1 and dmem_ack_i=0; freeze_o=1 combinationally in that cycle and throughout MEMWAIT.
REQ-009 MEMWAIT SHALL exit to RUN on the cycle after dmem_ack_i=1; freeze_o SHALL drop in the ack cycle.
REQ-010 A wait counter SHALL count MEMWAIT cycles; reaching MEM_TIMEOUT SHALL set mem_err_o until reset; freeze continues until ack; counter saturates and clears on exit.
REQ-011 Load-use hazard (id_ex_memrd_i=1, id_ex_rd_i!=0, id_ex_rd_i equals id_rs1_i or id_rs2_i) in RUN SHALL assert stall_if_o, stall_id_o, flush_ex_o for exactly one cycle and move to LDSTALL; LDSTALL returns to RUN next cycle with no further stall.
REQ-012 branch_taken_i=1 in RUN or LDSTALL SHALL assert flush_id_o and flush_ex_o that cycle and move to FLUSH; FLUSH ignores branch_taken_i and load-use, returning to RUN next cycle.
REQ-013 Priority SHALL be freeze > branch flush > load-use stall; while freeze_o=1, stall/flush outputs are 0.
REQ-014 Forwarding SHALL remain active during freeze, stall and flush.

Reset
REQ-015 While rst_i=1, all outputs SHALL be 0 and state RUN, regardless of inputs.
REQ-016 Reset asserted mid-MEMWAIT SHALL immediately drop freeze_o and clear mem_err_o and counters.

Configuration
REQ-017 With HAZARD_PERF_CNT_EN defined, stall_cnt_o SHALL increment each cycle stall_id_o or freeze_o is 1 and flush_cnt_o each cycle flush_id_o is 1, both saturating at all-ones.
REQ-018 Without HAZARD_PERF_CNT_EN, stall_cnt_o and flush_cnt_o SHALL be tied to 0 with no counter registers.

Verification
REQ-019 add x7,x4,x5 in MEM; add x8,x7,x6 in EX -> forward_a_o=2, forward_b_o=0.
REQ-020 add x7 in WB, x8 write in MEM; sub x3,x9,x7 in EX -> forward_a_o=0, forward_b_o=1; rd=x0 writes -> both 0.
REQ-021 ld x5 in EX, add x6,x5,x1 in ID -> one cycle stall_if/stall_id/flush_ex=1, state 0->1->0, stall_cnt_o +1.
REQ-022 branch_taken_i=1 concurrent with load-use -> flush_id_o=flush_ex_o=1, stall_id_o=0, state 3 for one cycle, flush_cnt_o +1.
REQ-023 load in MEM, dmem_ack_i low 3 cycles -> freeze_o=1 for 3 cycles, state 2, mem_err_o=0; ack low 16 cycles -> mem_err_o=1 after cycle 15, stays 1 after ack.
REQ-024 rst_i pulsed during MEMWAIT with mem_err_o=1 -> all outputs 0 immediately, state 0 after release.

Source files
------------

// File: rtl/as_hazard_ctrl.sv
// as_hazard_ctrl: pipeline hazard unit covering operand forwarding, load-use stall,
// branch flush and data-memory wait freeze with a sticky timeout error.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module as_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_ex_rd_i,
  input  logic                  id_ex_memrd_i,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd_i,
  input  logic                  ex_mem_reg_wr_i,
  input  logic                  ex_mem_memrd_i,
  input  logic                  ex_mem_memwr_i,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd_i,
  input  logic                  mem_wb_reg_wr_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_ack_i,
  output logic [1:0]            forward_a_o,
  output logic [1:0]            forward_b_o,
  output logic                  stall_if_o,
  output logic                  stall_id_o,
  output logic                  flush_id_o,
  output logic                  flush_ex_o,
  output logic                  freeze_o,
  output logic [1:0]            state_o,
  output logic                  mem_err_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    MEMWAIT = 2'd2,
    FLUSH   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               mem_err_q, mem_err_d;
  logic               mem_access;
  logic               load_use;

  // Operand source select: newest producer (EX/MEM) wins over MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                         input logic [REG_ADDR_W-1:0] ex_mem_rd,
                                         input logic                  ex_mem_wr,
                                         input logic [REG_ADDR_W-1:0] mem_wb_rd,
                                         input logic                  mem_wb_wr);
    if (ex_mem_wr && (ex_mem_rd != '0) && (ex_mem_rd == rs)) return 2'd2;
    if (mem_wb_wr && (mem_wb_rd != '0) && (mem_wb_rd == rs)) return 2'd1;
    return 2'd0;
  endfunction

  assign mem_access = ex_mem_memrd_i | ex_mem_memwr_i;
  assign load_use   = id_ex_memrd_i && (id_ex_rd_i != '0) &&
                      ((id_ex_rd_i == id_rs1_i) || (id_ex_rd_i == id_rs2_i));

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RUN;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and hazard outputs; reset forces every output low regardless of inputs.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q;
    forward_a_o = 2'd0;
    forward_b_o = 2'd0;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    freeze_o    = 1'b0;
    if (!rst_i) begin
      forward_a_o = fwd_sel(id_ex_rs1_i, ex_mem_rd_i, ex_mem_reg_wr_i, mem_wb_rd_i, mem_wb_reg_wr_i);
      forward_b_o = fwd_sel(id_ex_rs2_i, ex_mem_rd_i, ex_mem_reg_wr_i, mem_wb_rd_i, mem_wb_reg_wr_i);
      case (state_q)
        MEMWAIT: begin
          if (dmem_ack_i) state_d = RUN;
          else            freeze_o = 1'b1;
        end
        default: begin
          if (mem_access && !dmem_ack_i) begin
            freeze_o = 1'b1;
            state_d  = MEMWAIT;
          end else if (state_q == FLUSH) begin
            state_d = RUN;
          end else if (branch_taken_i) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
            state_d    = FLUSH;
          end else if ((state_q == RUN) && load_use) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
            state_d    = LDSTALL;
          end else begin
            state_d = RUN;
          end
        end
      endcase
      // Wait counter tracks frozen cycles, saturates at the timeout and clears once unfrozen.
      if (freeze_o) begin
        if (wait_q != WAIT_W'(MEM_TIMEOUT)) wait_d = wait_q + WAIT_W'(1);
        if (wait_d == WAIT_W'(MEM_TIMEOUT)) mem_err_d = 1'b1;
      end else begin
        wait_d = '0;
      end
    end
  end

  assign state_o   = state_q;
  assign mem_err_o = mem_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating performance counters for stall/freeze and flush cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall_id_o || freeze_o) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_id_o && (flush_cnt_q != '1))               flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_as_hazard_ctrl.sv
// Directed bench for as_hazard_ctrl: forwarding, load-use, branch flush, memory freeze/timeout, reset.
module tb_as_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
  logic       id_ex_memrd, ex_mem_reg_wr, ex_mem_memrd, ex_mem_memwr, mem_wb_reg_wr;
  logic       branch_taken, dmem_ack;
  logic [1:0] fwd_a, fwd_b, state;
  logic       stall_if, stall_id, flush_id, flush_ex, freeze, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  as_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_ex_rs1_i(id_ex_rs1), .id_ex_rs2_i(id_ex_rs2), .id_ex_rd_i(id_ex_rd),
    .id_ex_memrd_i(id_ex_memrd),
    .ex_mem_rd_i(ex_mem_rd), .ex_mem_reg_wr_i(ex_mem_reg_wr),
    .ex_mem_memrd_i(ex_mem_memrd), .ex_mem_memwr_i(ex_mem_memwr),
    .mem_wb_rd_i(mem_wb_rd), .mem_wb_reg_wr_i(mem_wb_reg_wr),
    .branch_taken_i(branch_taken), .dmem_ack_i(dmem_ack),
    .forward_a_o(fwd_a), .forward_b_o(fwd_b),
    .stall_if_o(stall_if), .stall_id_o(stall_id),
    .flush_id_o(flush_id), .flush_ex_o(flush_ex),
    .freeze_o(freeze), .state_o(state), .mem_err_o(mem_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic clear_in();
    {id_rs1, id_rs2, id_ex_rs1, id_ex_rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
    {id_ex_memrd, ex_mem_reg_wr, ex_mem_memrd, ex_mem_memwr, mem_wb_reg_wr} = '0;
    branch_taken = 1'b0;
    dmem_ack     = 1'b0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    // Reset with hostile inputs: everything must stay low.
    ex_mem_reg_wr = 1'b1; ex_mem_rd = 5'd7; id_ex_rs1 = 5'd7;
    ex_mem_memrd = 1'b1; branch_taken = 1'b1;
    #2;
    chk("rst_fwd_a", 32'(fwd_a), 32'd0);
    chk("rst_freeze", 32'(freeze), 32'd0);
    chk("rst_flush_id", 32'(flush_id), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    cyc(); cyc();
    clear_in();
    rst = 1'b0;

    // add x7 in MEM, add x8,x7,x6 in EX
    cyc();
    ex_mem_reg_wr = 1'b1; ex_mem_rd = 5'd7; id_ex_rs1 = 5'd7; id_ex_rs2 = 5'd6;
    #2;
    chk("fwd19_a", 32'(fwd_a), 32'd2);
    chk("fwd19_b", 32'(fwd_b), 32'd0);
    mem_wb_reg_wr = 1'b1; mem_wb_rd = 5'd7;
    #1;
    chk("fwd_prio_a", 32'(fwd_a), 32'd2);

    // add x7 in WB, x8 in MEM, sub x3,x9,x7 in EX
    cyc();
    ex_mem_rd = 5'd8; id_ex_rs1 = 5'd9; id_ex_rs2 = 5'd7;
    #2;
    chk("fwd20_a", 32'(fwd_a), 32'd0);
    chk("fwd20_b", 32'(fwd_b), 32'd1);
    ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0;
    #1;
    chk("fwd_x0_a", 32'(fwd_a), 32'd0);
    chk("fwd_x0_b", 32'(fwd_b), 32'd0);
    ex_mem_reg_wr = 1'b0; ex_mem_rd = 5'd5; mem_wb_reg_wr = 1'b0; id_ex_rs1 = 5'd5;
    #1;
    chk("fwd_nowr_a", 32'(fwd_a), 32'd0);

    // ld x5 in EX, add x6,x5,x1 in ID
    cyc();
    clear_in();
    id_ex_memrd = 1'b1; id_ex_rd = 5'd5; id_rs1 = 5'd5; id_rs2 = 5'd1;
    #2;
    chk("lu_stall_if", 32'(stall_if), 32'd1);
    chk("lu_stall_id", 32'(stall_id), 32'd1);
    chk("lu_flush_ex", 32'(flush_ex), 32'd1);
    chk("lu_flush_id", 32'(flush_id), 32'd0);
    chk("lu_state0", 32'(state), 32'd0);
    cyc();
    #2;
    chk("lu_state1", 32'(state), 32'd1);
    chk("lu_no_restall", 32'(stall_id), 32'd0);
    chk("lu_stall_cnt", stall_cnt, cnt(1));
    cyc();
    clear_in();
    #2;
    chk("lu_state_back", 32'(state), 32'd0);

    // Branch taken concurrent with load-use
    cyc();
    id_ex_memrd = 1'b1; id_ex_rd = 5'd5; id_rs2 = 5'd5; branch_taken = 1'b1;
    #2;
    chk("br_flush_id", 32'(flush_id), 32'd1);
    chk("br_flush_ex", 32'(flush_ex), 32'd1);
    chk("br_stall_id", 32'(stall_id), 32'd0);
    chk("br_stall_if", 32'(stall_if), 32'd0);
    cyc();
    #2;
    chk("br_state3", 32'(state), 32'd3);
    chk("br_flush_ign", 32'(flush_id), 32'd0);
    chk("br_lu_ign", 32'(stall_id), 32'd0);
    chk("br_flush_cnt", flush_cnt, cnt(1));
    cyc();
    clear_in();
    #2;
    chk("br_state_back", 32'(state), 32'd0);

    // Load in MEM, ack low 3 cycles; first cycle also carries branch + load-use + forwarding
    cyc();
    ex_mem_memrd = 1'b1; ex_mem_reg_wr = 1'b1; ex_mem_rd = 5'd3; id_ex_rs1 = 5'd3;
    branch_taken = 1'b1; id_ex_memrd = 1'b1; id_ex_rd = 5'd4; id_rs1 = 5'd4;
    #2;
    chk("mw1_freeze", 32'(freeze), 32'd1);
    chk("mw1_flush_id", 32'(flush_id), 32'd0);
    chk("mw1_stall_id", 32'(stall_id), 32'd0);
    chk("mw1_fwd_a", 32'(fwd_a), 32'd2);
    cyc();
    branch_taken = 1'b0; id_ex_memrd = 1'b0;
    #2;
    chk("mw2_state", 32'(state), 32'd2);
    chk("mw2_freeze", 32'(freeze), 32'd1);
    cyc();
    #2;
    chk("mw3_freeze", 32'(freeze), 32'd1);
    chk("mw3_mem_err", 32'(mem_err), 32'd0);
    cyc();
    dmem_ack = 1'b1;
    #2;
    chk("mw_ack_freeze", 32'(freeze), 32'd0);
    chk("mw_ack_state", 32'(state), 32'd2);
    cyc();
    clear_in();
    #2;
    chk("mw_exit_state", 32'(state), 32'd0);
    chk("mw_stall_cnt", stall_cnt, cnt(4));
    chk("mw_flush_cnt", flush_cnt, cnt(1));

    // Store in MEM, ack low 16 cycles: timeout after the 15th
    for (int i = 1; i <= 16; i++) begin
      cyc();
      ex_mem_memwr = 1'b1;
      #2;
      chk($sformatf("to_freeze_%0d", i), 32'(freeze), 32'd1);
      chk($sformatf("to_err_%0d", i), 32'(mem_err), (i > 15) ? 32'd1 : 32'd0);
    end
    cyc();
    dmem_ack = 1'b1;
    #2;
    chk("to_ack_freeze", 32'(freeze), 32'd0);
    chk("to_ack_err", 32'(mem_err), 32'd1);
    cyc();
    clear_in();
    #2;
    chk("to_exit_state", 32'(state), 32'd0);
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    chk("to_stall_cnt", stall_cnt, cnt(20));

    // Reset pulsed mid-MEMWAIT with error set
    cyc();
    ex_mem_memrd = 1'b1;
    ex_mem_reg_wr = 1'b1; ex_mem_rd = 5'd2; id_ex_rs2 = 5'd2;
    cyc();
    #2;
    chk("rw_state", 32'(state), 32'd2);
    chk("rw_fwd_b", 32'(fwd_b), 32'd2);
    rst = 1'b1;
    #1;
    chk("rw_freeze", 32'(freeze), 32'd0);
    chk("rw_mem_err", 32'(mem_err), 32'd0);
    chk("rw_state_rst", 32'(state), 32'd0);
    chk("rw_fwd_b_rst", 32'(fwd_b), 32'd0);
    chk("rw_stall_cnt", stall_cnt, 32'd0);
    chk("rw_flush_cnt", flush_cnt, 32'd0);
    cyc();
    clear_in();
    rst = 1'b0;
    cyc();
    #2;
    chk("post_rst_state", 32'(state), 32'd0);
    chk("post_rst_err", 32'(mem_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
